// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
// Optional checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CHECK,
    ST_FLUSH,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_BYTES      = 2;
  localparam int WADDR_SHIFT    = 2;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Collects four bytes, LSB first, into a 32-bit word.
// word_o and full_o update one edge after the fourth byte is shifted in.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
  output logic [1:0]  cnt_o,
  output logic        full_o,
  output logic [31:0] word_o
);

  logic [1:0]  cnt_q;
  logic        full_q;
  logic [23:0] part_q;
  logic [31:0] word_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      full_q <= 1'b0;
      part_q <= '0;
      word_q <= '0;
    end else begin
      full_q <= 1'b0;
      if (clear_i) begin
        cnt_q  <= '0;
        part_q <= '0;
        word_q <= '0;
      end else if (shift_i) begin
        cnt_q <= cnt_q + 2'd1;
        // Earlier bytes sit in the low lanes; the newest byte becomes the MSB.
        if (cnt_q == 2'(BYTES_PER_WORD - 1)) begin
          word_q <= {byte_i, part_q};
          full_q <= 1'b1;
        end else begin
          part_q <= {byte_i, part_q[23:8]};
        end
      end
    end
  end

  assign cnt_o  = cnt_q;
  assign full_o = full_q;
  assign word_o = word_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length header from a byte stream, writes 32-bit words to
// instruction memory and holds the core in reset until done. IMEM_LOADER_CHECKSUM_EN adds a check byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded
);

  state_e            state_q;
  logic [7:0]        len_lo_q;
  logic [15:0]       len_q;
  logic [15:0]       words_q;
  logic [ADDR_W-1:0] waddr_q;

  logic        accept;
  logic        restart;
  logic        word_end;
  logic        last_word;
  logic [15:0] len_next;
  logic [1:0]  asm_cnt;
  logic        asm_full;
  logic [31:0] asm_word;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e AFTER_DATA = ST_CHECK;
  logic [7:0] csum_q;
  assign rx_ready = state_q inside {ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CHECK};
`else
  localparam state_e AFTER_DATA = ST_FLUSH;
  assign rx_ready = state_q inside {ST_LEN_LO, ST_LEN_HI, ST_DATA};
`endif

  assign accept    = rx_valid && rx_ready;
  assign restart   = start && (state_q inside {ST_IDLE, ST_DONE, ST_ERR});
  assign word_end  = accept && (state_q == ST_DATA) && (asm_cnt == 2'(BYTES_PER_WORD - 1));
  assign last_word = (words_q == len_q - 16'd1);
  assign len_next  = {rx_data, len_lo_q};

  word_assembler u_asm (
    .clk     (clk),
    .rst     (rst),
    .clear_i (restart),
    .shift_i (accept && (state_q == ST_DATA)),
    .byte_i  (rx_data),
    .cnt_o   (asm_cnt),
    .full_o  (asm_full),
    .word_o  (asm_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      len_lo_q <= '0;
      len_q    <= '0;
      words_q  <= '0;
      waddr_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (accept) csum_q <= csum_q ^ rx_data;
`endif
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state_q <= ST_LEN_LO;
            len_q   <= '0;
            words_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
          end
        end
        ST_LEN_LO: begin
          if (accept) begin
            len_lo_q <= rx_data;
            state_q  <= ST_LEN_HI;
          end
        end
        ST_LEN_HI: begin
          if (accept) begin
            len_q <= len_next;
            if (len_next > 16'(DEPTH))   state_q <= ST_ERR;
            else if (len_next == 16'd0)  state_q <= AFTER_DATA;
            else                         state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          // Address is latched alongside the word so both appear with the write strobe.
          if (word_end) begin
            waddr_q <= ADDR_W'(words_q) << WADDR_SHIFT;
            words_q <= words_q + 16'd1;
            if (last_word) state_q <= AFTER_DATA;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (accept) state_q <= (rx_data == csum_q) ? ST_FLUSH : ST_ERR;
        end
`endif
        ST_FLUSH: state_q <= ST_DONE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign imem_we      = asm_full;
  assign imem_wdata   = asm_word;
  assign imem_waddr   = waddr_q;
  assign busy         = state_q inside {ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CHECK, ST_FLUSH};
  assign done         = (state_q == ST_DONE);
  assign error        = (state_q == ST_ERR);
  assign cpu_rst      = (state_q != ST_DONE);
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboarded bench for imem_loader: directed boot images plus randomized images with gaps.
// Follows the DUT build: define IMEM_LOADER_CHECKSUM_EN for both to test the check byte.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 32;

  logic              clk;
  logic              rst;
  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic              error;
  logic [15:0]       words_loaded;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  img_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] tb_mem[DEPTH];

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .imem_we      (imem_we),
    .imem_waddr   (imem_waddr),
    .imem_wdata   (imem_wdata),
    .cpu_rst      (cpu_rst),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin : monitor
    logic [31:0] ea;
    logic [31:0] ed;
    if (imem_we !== 1'b0) begin
      if (exp_addr_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, expected no write", imem_waddr, imem_wdata);
      end else begin
        ea = exp_addr_q.pop_front();
        ed = exp_data_q.pop_front();
        check("write_addr", imem_waddr, ea);
        check("write_data", imem_wdata, ed);
        $display("write addr=0x%08h data=0x%08h", imem_waddr, imem_wdata);
      end
      if (imem_waddr < 32'(DEPTH * 4)) tb_mem[imem_waddr[5:2]] = imem_wdata;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit poke);
    bit got;
    got = 1'b0;
    rx_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      if (poke && g == 0) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      got = (rx_ready === 1'b1);
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL rx_ready_timeout: got rx_ready=%b for 50 cycles, expected 1", rx_ready);
    end
    @(posedge clk); #1;
  endtask

  // Reference model: derives expected writes and final status from img_q (header + data).
  task automatic run_load(input int gap, input bit corrupt, input bit poke);
    int          n;
    int          nsend;
    bit          hdr_err;
    bit          ok;
    longint      w;
    logic [7:0]  x;
    logic [7:0]  stream[$];
    n       = int'({img_q[1], img_q[0]});
    hdr_err = (n > DEPTH);
    stream  = img_q;
    x       = 8'h00;
    foreach (img_q[i]) x ^= img_q[i];
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (!hdr_err) stream.push_back(corrupt ? ~x : x);
    ok = !hdr_err && !corrupt;
`else
    ok = !hdr_err;
`endif
    nsend = hdr_err ? HDR_BYTES : stream.size();
    if (!hdr_err) begin
      for (int i = 0; i < n; i++) begin
        w = 0;
        for (int k = BYTES_PER_WORD - 1; k >= 0; k--)
          w = w * 256 + longint'(img_q[HDR_BYTES + i * BYTES_PER_WORD + k]);
        exp_addr_q.push_back(32'(i * BYTES_PER_WORD));
        exp_data_q.push_back(32'(w));
      end
    end
    pulse_start();
    for (int i = 0; i < nsend; i++)
      send_byte(stream[i], gap, poke && (i == HDR_BYTES + 1));
    rx_valid = 1'b0;
    @(negedge clk);
    check("done_early", 32'(done), 32'(0));
    check("busy_flush", 32'(busy), 32'(ok));
    @(negedge clk);
    check("done", 32'(done), 32'(ok));
    check("error", 32'(error), 32'(!ok));
    check("cpu_rst", 32'(cpu_rst), 32'(!ok));
    check("rx_ready_end", 32'(rx_ready), 32'(0));
    check("busy_end", 32'(busy), 32'(0));
    check("words_loaded", 32'(words_loaded), hdr_err ? 32'(0) : 32'(n));
    check("writes_pending", 32'(exp_addr_q.size()), 32'(0));
    $display("load N=%0d gap=%0d corrupt=%0d xor=%02h -> done=%0d error=%0d words=%0d",
             n, gap, corrupt, x, done, error, words_loaded);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'(1));
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'(0));
    check({tag, "_imem_we"}, 32'(imem_we), 32'(0));
    check({tag, "_waddr"}, imem_waddr, 32'(0));
    check({tag, "_wdata"}, imem_wdata, 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_done"}, 32'(done), 32'(0));
    check({tag, "_error"}, 32'(error), 32'(0));
    check({tag, "_words"}, 32'(words_loaded), 32'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst      = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    foreach (tb_mem[i]) tb_mem[i] = 32'h0;

    // Reset held for two cycles.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    $display("reset check done");
    @(posedge clk); #1;
    rst = 1'b0;

    // Two-word image, back-to-back bytes.
    img_q = '{8'h02, 8'h00, 8'h93, 8'h01, 8'h00, 8'h00, 8'h13, 8'h02, 8'h40, 8'h00};
    run_load(0, 1'b0, 1'b0);

    // Same image with 3-cycle gaps and a start pulse while busy.
    run_load(3, 1'b0, 1'b1);

    // Oversized header, then a valid image recovers.
    img_q = '{8'h11, 8'h00};
    run_load(0, 1'b0, 1'b0);
    img_q = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    run_load(1, 1'b0, 1'b0);

    // Empty image.
    img_q = '{8'h00, 8'h00};
    run_load(0, 1'b0, 1'b0);

    // Full-depth image at the boundary.
    img_q.delete();
    img_q.push_back(8'(DEPTH));
    img_q.push_back(8'h00);
    for (int i = 0; i < DEPTH * BYTES_PER_WORD; i++) img_q.push_back(8'($urandom));
    run_load(0, 1'b0, 1'b0);

    // Reset after five data bytes: one word already committed.
    tb_mem[0] = 32'h0;
    exp_addr_q.push_back(32'h0);
    exp_data_q.push_back(32'h0000_0193);
    pulse_start();
    img_q = '{8'h02, 8'h00, 8'h93, 8'h01, 8'h00, 8'h00, 8'h13};
    foreach (img_q[i]) send_byte(img_q[i], 0, 1'b0);
    rx_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("midrst");
    check("retained_word", tb_mem[0], 32'h0000_0193);
    check("midrst_pending", 32'(exp_addr_q.size()), 32'(0));
    $display("mid-load reset check done");
    @(posedge clk); #1;
    rst = 1'b0;
    img_q = '{8'h01, 8'h00, 8'hB3, 8'h00, 8'h00, 8'h00};
    run_load(0, 1'b1, 1'b0);

    // Randomized images, gaps and checksum corruption.
    for (int k = 0; k < 12; k++) begin
      n = $urandom_range(0, DEPTH + 1);
      img_q.delete();
      img_q.push_back(8'(n));
      img_q.push_back(8'(n >> 8));
      if (n <= DEPTH)
        for (int i = 0; i < n * BYTES_PER_WORD; i++) img_q.push_back(8'($urandom));
      run_load($urandom_range(0, 2), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time controller that fills the writable instruction memory from a byte-serial stream, such as a UART receiver, before the core runs. It parses a length header and assembles little-endian bytes into 32-bit instructions. It issues one word write per instruction at consecutive word addresses and holds the core in reset until the image is committed. It sits between the byte receiver, the instruction memory write port and the core reset input.

Parameters:
- DEPTH, 16, instruction memory size in 32-bit words; maximum loadable image.
- ADDR_W, 32, width of the instruction memory byte address.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERR
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts a byte this cycle
- imem_we  out  1  instruction memory write strobe, one-cycle pulse
- imem_waddr  out  ADDR_W  byte address of the write, word aligned
- imem_wdata  out  32  instruction word
- cpu_rst  out  1  core reset, active high
- busy  out  1  load in progress
- done  out  1  image loaded, core released
- error  out  1  load aborted
- words_loaded  out  16  count of words written in the current load

Behaviour:
- Handshake: a byte is accepted on any cycle with rx_valid && rx_ready. rx_ready is combinational from the state: 1 in LEN_LO, LEN_HI and DATA (and CHECK when the optional feature is built); 0 in every other state.
- Image stream format: N[7:0], N[15:8], then N×4 bytes, each word sent LSB first.
- States and transitions:
  - IDLE: wait for start, then go to LEN_LO.
  - LEN_LO: capture N[7:0].
  - LEN_HI: capture N[15:8], then:
    - N > DEPTH → ERR.
    - N == 0 → FLUSH.
    - otherwise → DATA.
  - DATA: shift bytes into the assembler.
    - On the 4th byte of a word, the registered outputs at the next edge are imem_we=1, imem_wdata = {b3,b2,b1,b0}, imem_waddr = word_idx×4; word_idx and words_loaded then increment.
    - After the last byte of word N-1 → FLUSH.
  - FLUSH: one cycle, so the final write commits while cpu_rst is still high; then DONE.
  - DONE: done=1, cpu_rst=0, busy=0. A start pulse restarts the load: go to LEN_LO, cpu_rst=1, done=0, counters cleared.
  - ERR: error=1, cpu_rst=1, no further writes. A start pulse restarts as in DONE.
- Timing for the last byte: if it is accepted in cycle T, imem_we=1 in T+1 (FLUSH) and done=1 / cpu_rst=0 from T+2.
- busy = 1 in LEN_LO, LEN_HI, DATA, CHECK and FLUSH.
- Reset values: state IDLE, cpu_rst=1, rx_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, busy=0, done=0, error=0, words_loaded=0, assembler cleared.
- Reset mid-operation aborts the load and returns to the reset values. Partially written memory contents are not cleared.
- start while busy is ignored.
- rx_valid gaps of any length are legal; the assembler holds partial bytes.
- Write addresses never exceed (DEPTH-1)×4; the N check guarantees this.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - One extra byte follows the data (state CHECK, also entered from LEN_HI when N == 0).
  - It must equal the XOR of all 2 + 4N preceding bytes.
  - Match → FLUSH/DONE.
  - Mismatch → ERR. Words already written remain, and cpu_rst stays high.
- Undefined: no CHECK state. DATA (or N == 0) goes directly to FLUSH.

Decomposition:
- Package imem_loader_pkg:
  - state enum (IDLE, LEN_LO, LEN_HI, DATA, CHECK, FLUSH, DONE, ERR);
  - BYTES_PER_WORD = 4;
  - HDR_BYTES = 2;
  - localparam for word-address shift = 2.
- Sub-module word_assembler:
  - inputs: 8-bit byte shift-in, clear;
  - outputs: 2-bit byte counter, word_full pulse, assembled little-endian 32-bit word.

Test Plan:
1. Reset held 2 cycles → cpu_rst=1, rx_ready=0, imem_we=0, done=0, error=0, words_loaded=0.
2. start, then bytes 02 00 93 01 00 00 13 02 40 00 with rx_valid held high →
   - imem_we pulses write 0x00000193 to addr 0x0 and 0x00400213 to addr 0x4;
   - words_loaded=2;
   - done=1 and cpu_rst=0 exactly 2 cycles after the last byte is accepted.
3. Same image with rx_valid low for 3 cycles between every byte → identical writes, addresses and final state; no extra imem_we.
4. Header 11 00 (N=17, DEPTH=16) → ERR after the second byte; error=1, rx_ready=0, cpu_rst=1, no imem_we. A following start plus a valid image → DONE.
5. Header 00 00 → no writes; done=1 two cycles after LEN_HI (checksum build: after check byte 00).
6. rst asserted after 5 data bytes → reset values, one prior write retained in memory. Fresh start plus a 1-word image (01 00 B3 00 00 00) → write 0x000000B3 to addr 0x0, done=1. Checksum build: wrong check byte → error=1, cpu_rst=1.
